alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: setpoint editing from a set pushbutton, and an
// IDLE/ARMED/RINGING/SNOOZE state machine driven by time match and second ticks.
module alarm_ctrl #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       PB,
  input  logic [1:0] SWITCH,
  input  logic       SNOOZE_PB,
  input  logic [4:0] H_IN,
  input  logic [5:0] M_IN,
  input  logic [5:0] S_IN,
  output logic [4:0] ALARM_H,
  output logic [5:0] ALARM_M,
  output logic       ARMED,
  output logic       OUT_LED
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_RINGING = 2'd2;
  localparam logic [1:0] S_SNOOZE  = 2'd3;

  localparam logic [1:0] SW_HOURS  = 2'b00;
  localparam logic [1:0] SW_MINS   = 2'b01;
  localparam logic [1:0] SW_TOGGLE = 2'b10;

  localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * 60);
  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  logic [1:0] state;
  logic [7:0] ring_cnt;
  logic [9:0] snz_cnt;
  logic       pb_q;
  logic       snz_pb_q;
  logic       match_q;

  logic pb_edge;
  logic snz_edge;
  logic toggle;
  logic match;
  logic trigger;

  assign pb_edge  = PB & ~pb_q;
  assign snz_edge = SNOOZE_PB & ~snz_pb_q;
  assign toggle   = pb_edge & (SWITCH == SW_TOGGLE);
  // Compared against the live setpoint, so an edit that lands on the current time fires.
  assign match    = (H_IN == ALARM_H) & (M_IN == ALARM_M) & (S_IN == 6'd0);
  assign trigger  = match & ~match_q;

  assign ARMED   = (state != S_IDLE);
  assign OUT_LED = (state == S_RINGING);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pb_q     <= 1'b0;
      snz_pb_q <= 1'b0;
      match_q  <= 1'b0;
      ALARM_H  <= 5'd0;
      ALARM_M  <= 6'd0;
    end else begin
      pb_q     <= PB;
      snz_pb_q <= SNOOZE_PB;
      match_q  <= match;
      if (pb_edge && SWITCH == SW_HOURS)
        ALARM_H <= (ALARM_H == 5'd23) ? 5'd0 : ALARM_H + 5'd1;
      if (pb_edge && SWITCH == SW_MINS)
        ALARM_M <= (ALARM_M == 6'd59) ? 6'd0 : ALARM_M + 6'd1;
    end
  end

  // Each branch checks events in priority order: toggle, snooze, expiry, trigger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ring_cnt <= 8'd0;
      snz_cnt  <= 10'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (toggle) state <= S_ARMED;
        end
        S_ARMED: begin
          if (toggle) begin
            state <= S_IDLE;
          end else if (trigger) begin
            state    <= S_RINGING;
            ring_cnt <= 8'd0;
          end
        end
        S_RINGING: begin
          if (toggle) begin
            state <= S_IDLE;
          end else if (snz_edge) begin
            state   <= S_SNOOZE;
            snz_cnt <= SNZ_LOAD;
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) state <= S_ARMED;
            else                       ring_cnt <= ring_cnt + 8'd1;
          end
        end
        S_SNOOZE: begin
          if (toggle) begin
            state <= S_IDLE;
          end else if (sec_tick) begin
            if (snz_cnt == 10'd1) begin
              state    <= S_RINGING;
              ring_cnt <= 8'd0;
            end else begin
              snz_cnt <= snz_cnt - 10'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
